// File: rtl/lifofifo_pkg.sv
// lifofifo_pkg: shared mode encodings, defaults and count-width helper
package lifofifo_pkg;
  localparam logic MODE_FIFO = 1'b0;
  localparam logic MODE_LIFO = 1'b1;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 16;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/lifofifo_mem.sv
// lifofifo_mem: DEPTH x DATA_W storage, synchronous write, combinational read
module lifofifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/lifofifo_buf.sv
// lifofifo_buf: runtime FIFO/LIFO buffer with thresholds, count and error pulses
module lifofifo_buf
  import lifofifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              Mode,
  input  logic              Clr,
  input  logic [DATA_W-1:0] Datain,
  input  logic              Wren,
  input  logic              Rden,
  output logic [DATA_W-1:0] Dataout,
  output logic              Valid,
  output logic              Full,
  output logic              Empty,
  output logic              AlmostFull,
  output logic              AlmostEmpty,
  output logic [CW-1:0]     Count,
  output logic              Overflow,
  output logic              Underflow
);
  logic [AW-1:0] wr_ptr, rd_ptr, top, rd_addr, wr_addr, wr_nxt, rd_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [DATA_W-1:0] rdata;
  logic mode_q, lifo, rd_acc, wr_acc;
  assign Full = Count == CW'(DEPTH);
  assign Empty = Count == '0;
  assign AlmostFull = Count >= CW'(AF_LVL);
  assign AlmostEmpty = Count <= CW'(AE_LVL);
  assign lifo = mode_q == MODE_LIFO;
  assign top = wr_ptr - 1'b1;
  assign rd_acc = Rden && !Empty;
  assign wr_acc = Wren && (!Full || rd_acc);
  // a LIFO push+pop in one cycle overwrites the current top in place
  assign rd_addr = lifo ? top : rd_ptr;
  assign wr_addr = (lifo && rd_acc) ? top : wr_ptr;
  always_comb begin
    cnt_nxt = (wr_acc && !rd_acc) ? Count + 1'b1 : (rd_acc && !wr_acc) ? Count - 1'b1 : Count;
    wr_nxt = lifo ? ((wr_acc && !rd_acc) ? wr_ptr + 1'b1 : (rd_acc && !wr_acc) ? top : wr_ptr)
                  : (wr_acc ? wr_ptr + 1'b1 : wr_ptr);
    rd_nxt = (!lifo && rd_acc) ? rd_ptr + 1'b1 : rd_ptr;
  end
  lifofifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(wr_acc && !Clr),
    .waddr(wr_addr),
    .wdata(Datain),
    .raddr(rd_addr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge Rst)
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count <= '0;
      Dataout <= '0;
      Valid <= 1'b0;
      Overflow <= 1'b0;
      Underflow <= 1'b0;
      mode_q <= MODE_FIFO;
    end else begin
      if (Clr || Empty) mode_q <= Mode;
      wr_ptr <= Clr ? '0 : wr_nxt;
      rd_ptr <= Clr ? '0 : rd_nxt;
      Count <= Clr ? '0 : cnt_nxt;
      Valid <= !Clr && rd_acc;
      Overflow <= !Clr && Wren && !wr_acc;
      Underflow <= !Clr && Rden && !rd_acc;
      if (!Clr && rd_acc) Dataout <= rdata;
    end
endmodule

// File: tb/tb_lifofifo_buf.sv
// tb_lifofifo_buf: directed checks of FIFO/LIFO order, boundaries, mode latch, flush and reset
module tb_lifofifo_buf;
  logic clk = 0, rst_n = 0, mode = 0, clr = 0, wren = 0, rden = 0;
  logic [7:0] datain = '0, dataout;
  logic valid, full, empty, afull, aempty, ovf, udf;
  logic [3:0] count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  lifofifo_buf #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .Rst(rst_n), .Mode(mode), .Clr(clr), .Datain(datain),
    .Wren(wren), .Rden(rden), .Dataout(dataout), .Valid(valid),
    .Full(full), .Empty(empty), .AlmostFull(afull), .AlmostEmpty(aempty),
    .Count(count), .Overflow(ovf), .Underflow(udf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wren = w;
    rden = r;
    datain = d;
    @(posedge clk);
    #1;
    wren = 0;
    rden = 0;
  endtask
  initial begin
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", aempty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_valid", valid, 0);
    chk("rst_dout", dataout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'h11 + 8'(i));
      chk("fill_afull", afull, (i + 1) >= 6);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    step(1, 0, 8'h99);
    chk("ovf_pulse", ovf, 1);
    chk("ovf_count", count, 8);
    step(0, 0, 0);
    chk("ovf_clear", ovf, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      chk("fifo_dout", dataout, 8'h11 + 8'(i));
      chk("fifo_valid", valid, 1);
    end
    chk("fifo_empty", empty, 1);
    step(0, 1, 0);
    chk("udf_pulse", udf, 1);
    chk("udf_valid", valid, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 8'h21 + 8'(i));
    step(1, 1, 8'h29);
    chk("fullrw_dout", dataout, 8'h21);
    chk("fullrw_count", count, 8);
    chk("fullrw_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      chk("fullrw_drain", dataout, 8'h22 + 8'(i));
    end
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 8'h30 + 8'(i));
      step(0, 1, 0);
      chk("wrap_dout", dataout, 8'h30 + 8'(i));
    end
    chk("wrap_empty", empty, 1);
    mode = 1;
    step(1, 0, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk("lifo_dout", dataout, 8'hA3 - 8'(i));
      chk("lifo_valid", valid, 1);
      step(0, 0, 0);
      chk("lifo_vpulse", valid, 0);
    end
    step(1, 0, 8'h03);
    step(1, 0, 8'h05);
    step(1, 1, 8'h09);
    chk("lrw_dout", dataout, 8'h05);
    chk("lrw_count", count, 2);
    step(0, 1, 0);
    chk("lrw_pop1", dataout, 8'h09);
    step(0, 1, 0);
    chk("lrw_pop2", dataout, 8'h03);
    mode = 0;
    step(1, 0, 8'h01);
    step(1, 0, 8'h02);
    step(1, 0, 8'h03);
    mode = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk("latch_fifo", dataout, 8'(i + 1));
    end
    step(1, 0, 8'h41);
    step(1, 0, 8'h42);
    step(0, 1, 0);
    chk("latch_lifo1", dataout, 8'h42);
    step(0, 1, 0);
    chk("latch_lifo2", dataout, 8'h41);
    mode = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 8'h61 + 8'(i));
      chk("fill_aempty", aempty, (i + 1) <= 2);
    end
    chk("preclr_count", count, 5);
    clr = 1;
    step(1, 0, 8'hEE);
    clr = 0;
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);
    chk("clr_dout", dataout, 8'h41);
    chk("clr_valid", valid, 0);
    step(0, 1, 0);
    chk("clr_nowrite", udf, 1);
    step(1, 0, 8'h81);
    step(1, 0, 8'h82);
    step(1, 1, 8'h83);
    chk("burst_valid", valid, 1);
    chk("burst_dout", dataout, 8'h81);
    #2;
    rst_n = 0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_aempty", aempty, 1);
    chk("arst_valid", valid, 0);
    chk("arst_dout", dataout, 0);
    chk("arst_full", full, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lifofifo_buf.md
# lifofifo_buf

Single-clock, parametrised LIFO/FIFO buffer with a runtime-selectable order and width/depth generics. It adds almost-full/almost-empty thresholds, an occupancy count, overflow/underflow pulses and a synchronous flush. It sits between a producer and consumer on the same clock, with `Datain`/`Wren`/`Rden` semantics unchanged from the current LIFO/FIFO block.

## Interface
- `DATA_W`, 32, data width in bits.
- `DEPTH`, 16, number of entries; power of two, ≥ 4.
- `AF_LVL`, DEPTH-2, `AlmostFull` asserts when Count ≥ AF_LVL.
- `AE_LVL`, 2, `AlmostEmpty` asserts when Count ≤ AE_LVL.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `Mode`  in  1  0 = FIFO, 1 = LIFO; latched internally only when the buffer is empty.
- `Clr`  in  1  synchronous flush.
- `Datain`  in  DATA_W  write data.
- `Wren`  in  1  write request.
- `Rden`  in  1  read request.
- `Dataout`  out  DATA_W  registered read data.
- `Valid`  out  1  one-cycle pulse: `Dataout` carries a newly read word.
- `Full`, `Empty`, `AlmostFull`, `AlmostEmpty`  out  1 each  status flags.
- `Count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `Overflow`, `Underflow`  out  1 each  one-cycle pulse for a rejected write or read.

## Operation
- **Storage and pointers.** Storage is DEPTH words. `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is held in a register.
- **FIFO mode.**
  - Write: store at `wr_ptr`, then `wr_ptr+1`.
  - Read: output word at `rd_ptr`, then `rd_ptr+1`.
- **LIFO mode.**
  - Push: store at `wr_ptr`, then `wr_ptr+1`.
  - Pop: output word at `wr_ptr-1`, then `wr_ptr-1`.
  - `rd_ptr` is frozen, so an empty stack always has `wr_ptr == rd_ptr`.
- **Mode latching.** `mode_q <= Mode` on any edge where the current Count == 0 or `Clr` = 1. A `Mode` change while non-empty is ignored until the buffer drains.
- **Accept rules** (evaluated on pre-edge Count):
  - Write accepted if !Full, or if Full and a read is accepted in the same cycle.
  - Read accepted if !Empty.
- **Simultaneous accepted write and read.**
  - FIFO: both happen; Count is unchanged.
  - LIFO: `Dataout` takes the current top word, `Datain` replaces it, `wr_ptr` and Count are unchanged.
- **Empty with Wren+Rden:** the write is accepted, the read is rejected (Underflow pulses). There is no bypass.
- **Rejected requests.** A rejected write gives `Overflow` = 1 for the following cycle, with no state change. A rejected read gives `Underflow` = 1 for the following cycle, and `Valid` = 0.
- **Clr.** Priority over `Wren`/`Rden`. Pointers and Count go to 0, `Valid`/`Overflow`/`Underflow` go to 0, `Dataout` holds its value, and storage is not cleared.
- **Status flags** decode combinationally from the Count register:
  - `Full` = (Count == DEPTH)
  - `Empty` = (Count == 0)
  - `AlmostFull`, `AlmostEmpty` per the thresholds above.
- **Reset values:**
  - Pointers, Count, `Dataout`, `Valid`, `Overflow`, `Underflow` = 0.
  - `mode_q` = 0 (FIFO).
  - `Empty` = 1, `AlmostEmpty` = 1, `Full` = 0, `AlmostFull` = 0.
  - An assertion of `Rst` mid-operation discards all contents immediately.

## Timing
- Read latency is 1: `Rden` accepted at edge N gives `Dataout`/`Valid` valid after edge N, i.e. sampled at edge N+1.
- Write-to-read: a word written at edge N is readable by `Rden` at edge N+1. `Empty` deasserts after edge N.
- Flags and Count reflect all accepted operations one edge after the request.
- Sustained throughput is one write and one read per cycle in both modes.
- `Valid` is never high for two cycles unless `Rden` is accepted on consecutive edges.

## Structure
- **Package `lifofifo_pkg`:**
  - `MODE_FIFO` = 1'b0, `MODE_LIFO` = 1'b1.
  - Count-width helper (clog2(DEPTH)+1).
  - Default `DATA_W`/`DEPTH`.
- **Sub-module `lifofifo_mem`:** DEPTH × DATA_W array with synchronous write and combinational read address, no reset.
- **Top level:** pointers, Count, mode latch, accept logic, output register.

## Test plan
- **FIFO order:** DEPTH=8; reset; write 0x11..0x18 → Full = 1, Count = 8. Read 8 → `Dataout` 0x11..0x18 in order, Empty = 1.
- **LIFO order:** Mode = 1 while empty; push 0xA1, 0xA2, 0xA3; pop 3 → 0xA3, 0xA2, 0xA1, each with a single-cycle `Valid`.
- **Boundaries:**
  - Write when Full in FIFO → Overflow pulse, Count stays 8.
  - Read when Empty → Underflow pulse, `Valid` = 0.
  - Full with Wren+Rden in FIFO → both accepted, Count = 8.
- **Simultaneous ops in LIFO:** LIFO holding 0x5 top; Wren+Rden with `Datain` = 0x9 → `Dataout` = 0x5, next pop returns 0x9, Count unchanged. Pointer wrap covered by 20 FIFO write/read pairs with DEPTH=8.
- **Mode latch:** toggle `Mode` to LIFO while Count = 3 in FIFO → data still drains in FIFO order. Once Empty, LIFO takes effect.
- **Clr and reset:**
  - `Clr` with Count = 5 and Wren = 1 → Count = 0, Empty = 1, no write stored.
  - Drop `Rst` mid-burst → all outputs to their reset values asynchronously, before the next clock edge.
